// File: rtl/bp_pkg.sv
// Shared FSM type and saturating-counter helpers for branch-predictor tables.
package bp_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_e;

    // Weakly-not-taken value, i.e. the counter value just below the taken threshold.
    function automatic logic [3:0] wnt(input int ctrW);
        return 4'((1 << (ctrW - 1)) - 1);
    endfunction

    function automatic logic [3:0] sat_next(input logic [3:0] ctr, input logic taken, input int ctrW);
        logic [3:0] maxVal;
        maxVal = 4'((1 << ctrW) - 1);
        if (taken) begin
            return (ctr == maxVal) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/gshare_pred_if.sv
// Predict/update bus of the gshare predictor; master = fetch/resolve side, slave = predictor.
// Carries the statistics outputs when GSHARE_PRED_STATS_EN is defined.
interface gshare_pred_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 8
);
    logic             ready;
    logic             pred_req;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_vld;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_vld;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_pred;
`ifdef GSHARE_PRED_STATS_EN
    logic [31:0]      stat_upd;
    logic [31:0]      stat_mispred;

    modport master (
        input  ready, pred_vld, pred_taken, pred_idx, stat_upd, stat_mispred,
        output pred_req, pred_pc, upd_vld, upd_idx, upd_taken, upd_pred
    );
    modport slave (
        output ready, pred_vld, pred_taken, pred_idx, stat_upd, stat_mispred,
        input  pred_req, pred_pc, upd_vld, upd_idx, upd_taken, upd_pred
    );
`else
    modport master (
        input  ready, pred_vld, pred_taken, pred_idx,
        output pred_req, pred_pc, upd_vld, upd_idx, upd_taken, upd_pred
    );
    modport slave (
        output ready, pred_vld, pred_taken, pred_idx,
        input  pred_req, pred_pc, upd_vld, upd_idx, upd_taken, upd_pred
    );
`endif
endinterface

// File: rtl/bp_ctr_table.sv
// Saturating-counter table with a post-reset initialisation sweep, one read and one update port.
// Read is combinational from the flop array, so a same-cycle update is never visible to the read.
module bp_ctr_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             o_ready,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0] o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);
    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       WNT      = wnt(CTR_W);

    bp_state_e        r_state;
    bp_state_e        w_nextState;
    logic [IDX_W-1:0] r_ptr;
    logic [CTR_W-1:0] r_ctr [DEPTH];
    logic [3:0]       w_updNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == INIT) begin
                r_ptr <= r_ptr + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == INIT && r_ptr == LAST_PTR) begin
            w_nextState = RUN;
        end
    end

    assign o_ready   = (r_state == RUN);
    assign o_rd_ctr  = r_ctr[i_rd_idx];
    assign w_updNext = sat_next(4'(r_ctr[i_upd_idx]), i_upd_taken, CTR_W);

    // The array is not reset; the INIT sweep rewrites every entry before ready rises.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_ctr[r_ptr] <= WNT[CTR_W-1:0];
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= w_updNext[CTR_W-1:0];
        end
    end

endmodule

// File: rtl/gshare_pred.sv
// gshare direction predictor: PC slice XOR global history indexes a saturating-counter table.
// Define GSHARE_PRED_STATS_EN to add update/misprediction counters on the bus.
module gshare_pred
    import bp_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int PC_LSB = 2,
    parameter int IDX_W  = 8,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    gshare_pred_if.slave bus
);
    localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;

    logic [GHR_W-1:0] r_ghr;
    logic [IDX_W-1:0] w_pcSlice;
    logic [IDX_W-1:0] w_histExt;
    logic [IDX_W-1:0] w_idx;
    logic [CTR_W-1:0] w_rdCtr;
    logic             w_ready;
    logic             w_predEn;
    logic             w_updEn;
    logic             r_predVld;
    logic             r_predTaken;
    logic [IDX_W-1:0] r_predIdx;
    logic             w_unused;

    assign w_pcSlice = bus.pred_pc[PC_LSB +: IDX_W];

    generate
        if (HIST_W == 0) begin : g_noHist
            assign w_histExt = '0;
        end else begin : g_hist
            assign w_histExt = IDX_W'(r_ghr);
        end
    endgenerate

    assign w_idx    = w_pcSlice ^ w_histExt;
    assign w_predEn = w_ready && bus.pred_req;
    assign w_updEn  = w_ready && bus.upd_vld;
    assign w_unused = ^{bus.pred_pc, bus.upd_pred, r_ghr};

    bp_ctr_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .o_ready     (w_ready),
        .i_rd_idx    (w_idx),
        .o_rd_ctr    (w_rdCtr),
        .i_upd_en    (w_updEn),
        .i_upd_idx   (bus.upd_idx),
        .i_upd_taken (bus.upd_taken)
    );

    // History only advances on resolved branches, so wrong-path fetches never pollute it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_updEn) begin
            r_ghr <= (r_ghr << 1) | GHR_W'(bus.upd_taken);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_predVld   <= 1'b0;
            r_predTaken <= 1'b0;
            r_predIdx   <= '0;
        end else begin
            r_predVld <= w_predEn;
            if (w_predEn) begin
                r_predIdx   <= w_idx;
                r_predTaken <= w_rdCtr[CTR_W-1];
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.pred_vld   = r_predVld;
    assign bus.pred_taken = r_predTaken;
    assign bus.pred_idx   = r_predIdx;

`ifdef GSHARE_PRED_STATS_EN
    logic [31:0] r_statUpd;
    logic [31:0] r_statMispred;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_statUpd     <= '0;
            r_statMispred <= '0;
        end else if (w_updEn) begin
            if (r_statUpd != '1) begin
                r_statUpd <= r_statUpd + 32'd1;
            end
            if (bus.upd_pred != bus.upd_taken && r_statMispred != '1) begin
                r_statMispred <= r_statMispred + 32'd1;
            end
        end
    end

    assign bus.stat_upd     = r_statUpd;
    assign bus.stat_mispred = r_statMispred;
`endif

endmodule

// File: tb/tb_gshare_pred.sv
// Directed plus randomised scoreboard bench for gshare_pred (IDX_W=8, CTR_W=2, HIST_W=8).
// Expectations come from a behavioural model updated as each stimulus cycle is driven.
module tb_gshare_pred;

    localparam int DEPTH = 256;

    typedef struct {
        logic        ready;
        logic        vld;
        logic [7:0]  idx;
        logic        taken;
        logic [31:0] sUpd;
        logic [31:0] sMis;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFails = 0;

    exp_t       expQ[$];
    exp_t       monE;
    logic [1:0] mCtr [DEPTH];
    logic [7:0] mGhr;
    int         mInitLeft;
    logic [31:0] mUpd;
    logic [31:0] mMis;

    gshare_pred_if #(.PC_W(32), .IDX_W(8)) bus ();

    gshare_pred #(
        .PC_W   (32),
        .PC_LSB (2),
        .IDX_W  (8),
        .CTR_W  (2),
        .HIST_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] satModel(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [31:0] pcFor(input logic [7:0] idx);
        return {22'd0, idx ^ mGhr, 2'b00};
    endfunction

    // One stimulus cycle: drive at the falling edge, model the following rising edge.
    task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic uv,
                                 input logic [7:0] ui, input logic ut, input logic up);
        exp_t       e;
        logic [7:0] idx;
        logic       rdy;
        @(negedge clk);
        bus.pred_req  = req;
        bus.pred_pc   = pc;
        bus.upd_vld   = uv;
        bus.upd_idx   = ui;
        bus.upd_taken = ut;
        bus.upd_pred  = up;
        rdy     = (mInitLeft == 0);
        idx     = pc[9:2] ^ mGhr;
        e.vld   = rdy && req;
        e.idx   = idx;
        e.taken = mCtr[idx][1];
        if (rdy && uv) begin
            mCtr[ui] = satModel(mCtr[ui], ut);
            mGhr     = {mGhr[6:0], ut};
            if (mUpd != 32'hFFFF_FFFF) mUpd++;
            if (up != ut && mMis != 32'hFFFF_FFFF) mMis++;
        end
        if (mInitLeft > 0) mInitLeft--;
        e.ready = (mInitLeft == 0);
        e.sUpd  = mUpd;
        e.sMis  = mMis;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic predict(input logic [7:0] idx);
        applyStimulus(1'b1, pcFor(idx), 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [7:0] idx, input logic t, input logic p);
        applyStimulus(1'b0, 32'd0, 1'b1, idx, t, p);
    endtask

    // Asserts reset at a falling edge and releases it just after the next rising edge.
    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        bus.pred_req = 1'b0;
        bus.upd_vld  = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(bus.ready), 32'd0);
        checkOutput("rst_pred_vld", 32'(bus.pred_vld), 32'd0);
        checkOutput("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        checkOutput("rst_pred_idx", 32'(bus.pred_idx), 32'd0);
`ifdef GSHARE_PRED_STATS_EN
        checkOutput("rst_stat_upd", bus.stat_upd, 32'd0);
        checkOutput("rst_stat_mispred", bus.stat_mispred, 32'd0);
`endif
        for (int i = 0; i < DEPTH; i++) mCtr[i] = 2'b01;
        mGhr = 8'd0;
        mUpd = 32'd0;
        mMis = 32'd0;
        mInitLeft = DEPTH;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Scoreboard: each driven cycle's expectation is checked just after the edge it targets.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput("ready", 32'(bus.ready), 32'(monE.ready));
            checkOutput("pred_vld", 32'(bus.pred_vld), 32'(monE.vld));
            if (monE.vld) begin
                checkOutput("pred_idx", 32'(bus.pred_idx), 32'(monE.idx));
                checkOutput("pred_taken", 32'(bus.pred_taken), 32'(monE.taken));
            end
`ifdef GSHARE_PRED_STATS_EN
            checkOutput("stat_upd", bus.stat_upd, monE.sUpd);
            checkOutput("stat_mispred", bus.stat_mispred, monE.sMis);
`endif
        end
    end

    initial begin
        bus.pred_req  = 1'b0;
        bus.pred_pc   = 32'd0;
        bus.upd_vld   = 1'b0;
        bus.upd_idx   = 8'd0;
        bus.upd_taken = 1'b0;
        bus.upd_pred  = 1'b0;

        resetDut();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'(i % 3 == 0), 32'h40, 1'(i % 5 == 0), 8'h10, 1'b1, 1'b0);
        end
        for (int i = 0; i < 16; i++) predict(8'(i * 17));

        update(8'h10, 1'b1, 1'b0);
        update(8'h10, 1'b1, 1'b0);
        predict(8'h10);
        for (int i = 0; i < 5; i++) update(8'h10, 1'b1, 1'b1);
        predict(8'h10);
        for (int i = 0; i < 3; i++) update(8'h10, 1'b0, 1'b1);
        predict(8'h10);
        update(8'h10, 1'b0, 1'b0);
        predict(8'h10);

        resetDut();
        idle(DEPTH);
        update(8'h30, 1'b1, 1'b0);
        update(8'h31, 1'b1, 1'b0);
        update(8'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, pcFor(8'h16), 1'b1, 8'h16, 1'b1, 1'b0);
        predict(8'h16);

        for (int i = 0; i < 3; i++) update(8'h20, 1'b1, 1'b0);
        update(8'h20, 1'b0, 1'b1);
        predict(8'h20);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 1) ? pcFor(8'(8'h10 + $urandom_range(0, 3)))
                                                      : ($urandom & 32'h0000_03FC),
                          1'($urandom_range(0, 1)), 8'(8'h10 + $urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        resetDut();
        idle(100);
        resetDut();
        idle(DEPTH);
        for (int i = 0; i < 4; i++) predict(8'(8'h10 + i));
        applyStimulus(1'b1, 32'h40, 1'b0, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) update(8'(8'h40 + i), 1'(i % 2), (i < 3) ? 1'(1 - i % 2) : 1'(i % 2));
        idle(2);
        resetDut();
        idle(2);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/gshare_pred.md
Name: gshare_pred

Overview:
- Parametrised successor to the per-PC 2-bit predictor: gshare direction predictor.
- Table index = PC bits XOR global history register (GHR); table entries are N-bit saturating counters.
- Predict port (fetch) and update port (resolve) are decoupled; predictions are registered with 1-cycle latency.
- A table-initialisation sweep runs after reset; sits between fetch PC generation and branch resolution.

Parameters:
- PC_W, 32, program counter width.
- PC_LSB, 2, lowest PC bit used for indexing (drops instruction-alignment bits).
- IDX_W, 8, table index width; table depth = 2**IDX_W.
- CTR_W, 2, counter width; legal range 1..4.
- HIST_W, 8, GHR length; legal range 0..IDX_W; 0 = pure bimodal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  table initialised; predict and update are accepted only when high.
- pred_req  in  1  prediction request this cycle.
- pred_pc  in  PC_W  PC of the fetched branch.
- pred_vld  out  1  registered; high one cycle after an accepted pred_req.
- pred_taken  out  1  predicted direction (1 = taken).
- pred_idx  out  IDX_W  table index used; carried down the pipe and returned on upd_idx.
- upd_vld  in  1  resolved branch update.
- upd_idx  in  IDX_W  index returned from the prediction.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  direction that was predicted (used by the stats feature only; ignored otherwise).

Behaviour:
- Reset values: ready=0, pred_vld=0, pred_taken=0, pred_idx=0, GHR=0, FSM=INIT, sweep pointer=0.
- FSM states:
  - INIT: writes WNT = 2**(CTR_W-1)-1 to entry[ptr] each cycle; ptr increments.
  - INIT -> RUN when ptr = 2**IDX_W-1 is written; ready rises the next cycle.
  - INIT therefore lasts exactly 2**IDX_W cycles after reset release.
  - RUN: normal operation; stays in RUN until reset.
- In INIT, pred_req and upd_vld are ignored: pred_vld stays 0, no table or GHR change.
- Reset asserted mid-INIT or mid-RUN: immediate return to INIT with ptr=0; full sweep repeats.
- Index: idx = pred_pc[PC_LSB +: IDX_W] XOR zero-extended GHR[HIST_W-1:0]. HIST_W=0 gives idx = PC slice only.
- Predict:
  - Accepted when ready && pred_req.
  - Next cycle: pred_vld=1, pred_idx=idx, pred_taken = MSB of entry[idx] as it stood at the request edge.
  - pred_vld is 0 in any cycle without an accepted request; pred_taken and pred_idx hold their last values.
- Update, when ready && upd_vld:
  - entry[upd_idx] increments if upd_taken, else decrements.
  - Saturates at 2**CTR_W-1 and at 0; no wrap.
  - GHR <= {GHR[HIST_W-2:0], upd_taken}. GHR is updated non-speculatively at resolve only.
- Same-cycle predict and update:
  - The prediction reads the pre-update counter and the pre-update GHR (read-before-write).
  - This holds even when idx == upd_idx.
- Back-to-back updates to one index in consecutive cycles each see the previous result; no lost updates.
- Fully synchronous table (flops); no X on any output after reset.

Optional Feature:
- Macro: GSHARE_PRED_STATS_EN.
- Defined:
  - Adds outputs stat_upd[31:0] and stat_mispred[31:0], reset to 0.
  - stat_upd increments on each accepted update.
  - stat_mispred increments when upd_pred != upd_taken on an accepted update.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both counters are cleared by reset only; they do not clear at INIT end.
- Undefined: these ports and counters do not exist; upd_pred is unused.

Decomposition:
- Package bp_pkg:
  - FSM state enum {INIT, RUN}.
  - Counter-init constant function wnt(CTR_W).
  - Saturating next-value function sat_next(ctr, taken, CTR_W).
- Sub-module bp_ctr_table:
  - Counter array, INIT sweep pointer, ready generation.
  - One read port and one update port.
  - Reused by future tournament and BTB blocks.
- gshare_pred contains GHR, index hash, output pipeline register and stats.

Test Plan:
1. Reset release, IDX_W=8 -> ready rises exactly 256 cycles later; a pred_req during INIT yields no pred_vld; every entry reads 2'b01 (pred_taken=0).
2. HIST_W=0, pc=0x40, two taken updates on idx 0x10 -> next prediction pred_taken=1; five more taken updates keep the counter at 2'b11; three not-taken updates -> 2'b00, then one more leaves it at 2'b00.
3. HIST_W=8, updates taken,taken,not-taken -> GHR=8'b00000110; pred_pc=0x40 -> pred_idx=0x10^0x06=0x16, valid one cycle after the request.
4. Same-cycle pred_req and update on index 0x16, counter 2'b01, upd_taken=1 -> pred_taken=0 (old value); the following prediction gives 1.
5. Reset pulsed at cycle 100 of INIT and at a RUN cycle after training -> ready drops immediately; a new 256-cycle sweep runs; all counters return to 2'b01; GHR=0.
6. GSHARE_PRED_STATS_EN defined: 10 updates, 3 with upd_pred != upd_taken -> stat_upd=10, stat_mispred=3; reset -> both 0.
